// File: rtl/mux4_rr_arbiter.sv
// ---------------------------------------------------------------------------
// mux4_rr_arbiter
//
// Round-robin arbiter and sequencer for a shared 4:1 data mux. Four
// requesters each drive one data lane. One requester is granted at a time.
// While it keeps requesting, its lane is registered onto y, up to HOLD_MAX
// transfers per grant. After each grant the block spends one mandatory IDLE
// cycle, and the priority pointer rotates past the last winner so no
// requester can starve another.
//
// Parameters
//   DW        width of each data lane and of y
//   HOLD_MAX  maximum transfers per grant (1..255)
//
// Ports
//   clk      rising-edge clock
//   rst      asynchronous, active-high reset
//   req      request per requester; bit k belongs to requester k
//   d        data lanes; lane k is d[k*DW +: DW]
//   gnt      registered one-hot grant; all-zero when idle
//   sel      registered mux select; index of the granted requester
//   y        registered selected data
//   y_valid  y holds a transfer captured on the previous edge
//   busy     high while a grant is active (decoded from state)
// ---------------------------------------------------------------------------
module mux4_rr_arbiter #(
   parameter int DW       = 1,
   parameter int HOLD_MAX = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [3:0]      req,
   input  logic [4*DW-1:0] d,
   output logic [3:0]      gnt,
   output logic [1:0]      sel,
   output logic [DW-1:0]   y,
   output logic            y_valid,
   output logic            busy
);

   // The counter must be able to hold values up to HOLD_MAX-1.
   // Sizing it for HOLD_MAX+1 values keeps it at least one bit wide
   // when HOLD_MAX is 1.
   localparam int            CW   = $clog2(HOLD_MAX + 1);
   localparam logic [CW-1:0] LAST = CW'(HOLD_MAX - 1);

   typedef enum logic {
      IDLE,
      GRANT
   } state_t;

   state_t        state;
   logic [1:0]    ptr;
   logic [CW-1:0] cnt;
   logic [1:0]    winner;
   logic [1:0]    probe;
   logic          found;
   logic [DW-1:0] lane [4];

   // Split the packed data bus into lanes so the grant index can select
   // one lane directly.
   always_comb begin
      for (int k = 0; k < 4; k++) begin
         lane[k] = d[k*DW +: DW];
      end
   end

   // Rotating priority search. The scan starts at ptr and wraps modulo 4
   // through the 2-bit add. The first requester hit is the winner. When
   // nobody requests, the winner value is unused.
   always_comb begin
      winner = ptr;
      found  = 1'b0;
      probe  = ptr;
      for (int i = 0; i < 4; i++) begin
         probe = ptr + 2'(i);
         if (!found && req[probe]) begin
            winner = probe;
            found  = 1'b1;
         end
      end
   end

   // Grant sequencer.
   //
   // IDLE: accept the round-robin winner. A new grant never carries data
   // on its first edge, so y_valid drops here.
   //
   // GRANT: on each edge where the owner still requests, capture its lane.
   // Release when the owner drops its request, or on the last allowed
   // transfer. A request dropped on the final-count edge falls into the
   // no-transfer branch, so it is treated as an early drop.
   //
   // On release, sel and y keep their last values so downstream logic sees
   // a stable mux path during the idle bubble.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         gnt     <= 4'b0000;
         sel     <= 2'd0;
         ptr     <= 2'd0;
         cnt     <= '0;
         y       <= '0;
         y_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               y_valid <= 1'b0;
               if (|req) begin
                  gnt   <= 4'b0001 << winner;
                  sel   <= winner;
                  cnt   <= '0;
                  state <= GRANT;
               end
            end

            GRANT: begin
               if (req[sel]) begin
                  y       <= lane[sel];
                  y_valid <= 1'b1;
                  if (cnt == LAST) begin
                     gnt   <= 4'b0000;
                     state <= IDLE;
                     cnt   <= '0;
                     ptr   <= sel + 2'd1;
                  end else begin
                     cnt <= cnt + CW'(1);
                  end
               end else begin
                  y_valid <= 1'b0;
                  gnt     <= 4'b0000;
                  state   <= IDLE;
                  cnt     <= '0;
                  ptr     <= sel + 2'd1;
               end
            end

            default: begin
               state <= IDLE;
               gnt   <= 4'b0000;
               cnt   <= '0;
            end
         endcase
      end
   end

   assign busy = (state == GRANT);

endmodule
